// File: rtl/ipbase_intf_axi_rd_slave_simplified_v0p1.sv
// ----------------------------------------------------------------------------
// ipbase_intf_axi_rd_slave_simplified_v0p1
//
// AXI4 read responder serving INCR bursts from a fixed-latency synchronous
// memory. An AR request is turned into one memory read per beat. A tag
// {valid, id, last, err} travels alongside each read for MEM_RD_LATENCY cycles.
// When the tag emerges, the memory word is pushed into a small output FIFO
// whose head drives the R channel. Reads are issued only while credit remains
// (FIFO_DEPTH - fifo_count - in_flight > 0). Because of this, R backpressure
// can never cause returning memory data to be dropped.
//
// Ports:
//   sys_clk, sys_rst      clock, synchronous active-high reset
//   s_axi_ar*             AR channel (id, byte address, len, size, burst, handshake)
//   s_axi_r*              R channel (id, data, resp, last, handshake)
//   mem_rd_en/addr/data   synchronous memory read port, data valid
//                         MEM_RD_LATENCY cycles after mem_rd_en
//   dfx_cfg0              bit0 = hold DFX counters at zero
//   dfx_sta0              {state, fifo_count, in_flight, ar_cnt, rlast_cnt}
//
// FSM states:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | arready high, waiting for an AR handshake
//   ST_BURST | issuing one memory read per credited cycle until last beat
// ----------------------------------------------------------------------------
module ipbase_intf_axi_rd_slave_simplified_v0p1 #(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 512,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int MEM_RD_LATENCY = 2,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic                      mem_rd_en,
    output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [AXI_DATA_WIDTH-1:0] mem_rd_data,
    input  logic [31:0]               dfx_cfg0,
    output logic [31:0]               dfx_sta0
);

    localparam int               BYTE_SHIFT = $clog2(AXI_DATA_WIDTH / 8);
    localparam logic [2:0]       SIZE_C     = 3'(BYTE_SHIFT);
    localparam int               CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int               PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W:0]   DEPTH_C    = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_C     = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_MAX    = PTR_W'(FIFO_DEPTH - 1);
    localparam int               TAG_W      = AXI_ID_WIDTH + 3;
    localparam int               ENT_W      = AXI_ID_WIDTH + AXI_DATA_WIDTH + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1
    } state_t;

    state_t                    state_q, state_d;
    logic                      arready_q, arready_d;
    logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                rem_q, rem_d;
    logic                      err_q, err_d;

    logic [TAG_W-1:0]          tag_q [MEM_RD_LATENCY];
    logic [TAG_W-1:0]          tag_d [MEM_RD_LATENCY];

    logic [ENT_W-1:0]          fifo_mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]          fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          fifo_count_q, fifo_count_d;
    logic [CNT_W-1:0]          in_flight_q, in_flight_d;

    logic [7:0]                ar_cnt_q, ar_cnt_d;
    logic [7:0]                rlast_cnt_q, rlast_cnt_d;

    logic                      ar_hs;
    logic                      credit_ok;
    logic                      issue;
    logic                      issue_last;
    logic [TAG_W-1:0]          tag_out;
    logic                      push;
    logic [AXI_ID_WIDTH-1:0]   tag_id;
    logic                      tag_last;
    logic                      tag_err;
    logic                      pop;
    logic [ENT_W-1:0]          head;
    logic                      rvalid;
    logic                      unused_bits;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    // Credit uses only registered counts, so a pop this cycle frees a slot
    // from the next cycle onward.
    assign credit_ok  = ({1'b0, fifo_count_q} + {1'b0, in_flight_q}) < DEPTH_C;
    assign ar_hs      = s_axi_arvalid && arready_q;
    assign issue      = (state_q == ST_BURST) && credit_ok;
    assign issue_last = issue && (rem_q == 8'd0);

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (ar_hs) begin
                    id_d    = s_axi_arid;
                    addr_d  = s_axi_araddr[MEM_ADDR_WIDTH+BYTE_SHIFT-1:BYTE_SHIFT];
                    rem_d   = s_axi_arlen;
                    err_d   = (s_axi_arsize != SIZE_C) || (s_axi_arburst != 2'b01);
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (issue) begin
                    // Word address wraps naturally at 2^MEM_ADDR_WIDTH.
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 8'd1;
                    if (rem_q == 8'd0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // arready is registered so it rises the cycle after the last beat issues.
        arready_d = (state_d == ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Tag pipeline, aligned with memory read latency
    // ------------------------------------------------------------------
    always_comb begin
        tag_d[0] = {issue, id_q, issue_last, err_q};
        for (int i = 1; i < MEM_RD_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    assign tag_out  = tag_q[MEM_RD_LATENCY-1];
    assign push     = tag_out[TAG_W-1];
    assign tag_id   = tag_out[TAG_W-2:2];
    assign tag_last = tag_out[1];
    assign tag_err  = tag_out[0];

    // ------------------------------------------------------------------
    // Output FIFO and in-flight accounting
    // ------------------------------------------------------------------
    assign rvalid = (fifo_count_q != '0);
    assign pop    = rvalid && s_axi_rready;
    assign head   = fifo_mem_q[rd_ptr_q];

    always_comb begin
        fifo_mem_d   = fifo_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        in_flight_d  = in_flight_q;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = {tag_id, mem_rd_data, tag_last, tag_err};
            wr_ptr_d             = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + 1'b1;
            2'b01:   fifo_count_d = fifo_count_q - 1'b1;
            default: fifo_count_d = fifo_count_q;
        endcase
        case ({issue, push})
            2'b10:   in_flight_d = in_flight_q + 1'b1;
            2'b01:   in_flight_d = in_flight_q - 1'b1;
            default: in_flight_d = in_flight_q;
        endcase
    end

    // ------------------------------------------------------------------
    // DFX counters
    // ------------------------------------------------------------------
    always_comb begin
        ar_cnt_d    = ar_cnt_q;
        rlast_cnt_d = rlast_cnt_q;
        if (dfx_cfg0[0]) begin
            ar_cnt_d    = '0;
            rlast_cnt_d = '0;
        end else begin
            if (ar_hs) begin
                ar_cnt_d = ar_cnt_q + 8'd1;
            end
            if (pop && s_axi_rlast) begin
                rlast_cnt_d = rlast_cnt_q + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            arready_q    <= 1'b0;
            id_q         <= '0;
            addr_q       <= '0;
            rem_q        <= '0;
            err_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            in_flight_q  <= '0;
            ar_cnt_q     <= '0;
            rlast_cnt_q  <= '0;
            for (int i = 0; i < MEM_RD_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            arready_q    <= arready_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            err_q        <= err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            in_flight_q  <= in_flight_d;
            ar_cnt_q     <= ar_cnt_d;
            rlast_cnt_q  <= rlast_cnt_d;
            tag_q        <= tag_d;
        end
    end

    // FIFO storage carries no reset; outputs are masked while it is empty.
    always_ff @(posedge sys_clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    // The credit scheme guarantees there is always room for returning data.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            assert (!(push && !pop && (fifo_count_q == FULL_C)));
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid;
    assign s_axi_rid     = rvalid ? head[ENT_W-1:AXI_DATA_WIDTH+2] : '0;
    assign s_axi_rdata   = rvalid ? head[AXI_DATA_WIDTH+1:2] : '0;
    assign s_axi_rlast   = rvalid && head[1];
    assign s_axi_rresp   = (rvalid && head[0]) ? 2'b10 : 2'b00;
    assign mem_rd_en     = issue;
    assign mem_rd_addr   = addr_q;
    assign dfx_sta0      = {state_q, 6'(fifo_count_q), 8'(in_flight_q), ar_cnt_q, rlast_cnt_q};

    // Only the word-address slice of araddr and bit0 of dfx_cfg0 are used.
    assign unused_bits = ^{s_axi_araddr, dfx_cfg0};

endmodule

// File: tb/tb_ipbase_intf_axi_rd_slave_simplified_v0p1.sv
// ----------------------------------------------------------------------------
// Testbench for ipbase_intf_axi_rd_slave_simplified_v0p1.
// The memory is modelled as an L-cycle pipeline returning mem_word(addr).
// Each AR issued by the bench pushes its expected beats and read addresses
// into queues. Monitors pop from those queues and compare against the DUT.
// ----------------------------------------------------------------------------
module tb_ipbase_intf_axi_rd_slave_simplified_v0p1;

    localparam int L = 2;

    typedef struct packed {
        logic [3:0]   id;
        logic [511:0] data;
        logic         last;
        logic [1:0]   resp;
    } beat_t;

    logic         clk;
    logic         sys_rst;
    logic [3:0]   s_axi_arid;
    logic [63:0]  s_axi_araddr;
    logic [7:0]   s_axi_arlen;
    logic [2:0]   s_axi_arsize;
    logic [1:0]   s_axi_arburst;
    logic         s_axi_arvalid;
    logic         s_axi_arready;
    logic [3:0]   s_axi_rid;
    logic [511:0] s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rlast;
    logic         s_axi_rvalid;
    logic         s_axi_rready;
    logic         mem_rd_en;
    logic [15:0]  mem_rd_addr;
    logic [511:0] mem_rd_data;
    logic [31:0]  dfx_cfg0;
    logic [31:0]  dfx_sta0;

    logic [511:0] rd_pipe [L];

    beat_t        sb [$];
    logic [15:0]  exp_addr [$];
    int           rd_cyc [$];
    int           beat_cyc [$];

    int cyc      = 0;
    int n_assert = 0;
    int n_fail   = 0;
    int n_ar     = 0;
    int n_rlast  = 0;

    ipbase_intf_axi_rd_slave_simplified_v0p1 dut (
        .sys_clk       (clk),
        .sys_rst       (sys_rst),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_data   (mem_rd_data),
        .dfx_cfg0      (dfx_cfg0),
        .dfx_sta0      (dfx_sta0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [511:0] mem_word(input logic [15:0] a);
        return {16{16'hC0DE, a}};
    endfunction

    always @(posedge clk) begin
        rd_pipe[0] <= mem_rd_en ? mem_word(mem_rd_addr) : '0;
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rd_data = rd_pipe[L-1];

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory-read monitor: checks issued word addresses in order.
    always @(negedge clk) begin
        if (mem_rd_en) begin
            rd_cyc.push_back(cyc);
            chk_i("rd_expected", int'(exp_addr.size() > 0), 1);
            if (exp_addr.size() > 0) begin
                chk_i("mem_rd_addr", int'(mem_rd_addr), int'(exp_addr.pop_front()));
            end
        end
    end

    // R-channel monitor: scoreboard pop on each handshake.
    always @(negedge clk) begin
        if (s_axi_rvalid && s_axi_rready) begin
            beat_t e;
            beat_cyc.push_back(cyc);
            if (s_axi_rlast) n_rlast++;
            chk_i("beat_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk_i("rid", int'(s_axi_rid), int'(e.id));
                chk_w("rdata", s_axi_rdata, e.data);
                chk_i("rlast", int'(s_axi_rlast), int'(e.last));
                chk_i("rresp", int'(s_axi_rresp), int'(e.resp));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one AR; returns the handshake cycle. Entered and left at #1 after posedge.
    task automatic do_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int t);
        logic [15:0] w;
        logic        err;
        logic        got;
        w   = addr[21:6];
        err = (size != 3'd6) || (burst != 2'b01);
        for (int i = 0; i <= int'(len); i++) begin
            sb.push_back(beat_t'{id: id, data: mem_word(w + 16'(i)),
                                 last: (i == int'(len)), resp: (err ? 2'b10 : 2'b00)});
            exp_addr.push_back(w + 16'(i));
        end
        s_axi_arid    = id;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arsize  = size;
        s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        got = 1'b0;
        t   = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (s_axi_arready) begin
                got = 1'b1;
                t   = cyc;
            end
        end
        @(posedge clk);
        #1;
        s_axi_arvalid = 1'b0;
        chk_i("ar_accept", int'(got), 1);
        if (got) n_ar++;
    endtask

    task automatic wait_drain(input int budget);
        for (int k = 0; k < budget && sb.size() != 0; k++) tick(1);
        tick(2);
        chk_i("drain", sb.size(), 0);
    endtask

    initial begin
        int t, t2, nb, nr;
        sys_rst       = 1'b1;
        s_axi_arid    = '0;
        s_axi_araddr  = '0;
        s_axi_arlen   = '0;
        s_axi_arsize  = 3'd6;
        s_axi_arburst = 2'b01;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        dfx_cfg0      = '0;

        // Reset state
        tick(3);
        chk_i("rst_arready", int'(s_axi_arready), 0);
        chk_i("rst_rvalid", int'(s_axi_rvalid), 0);
        chk_i("rst_mem_rd_en", int'(mem_rd_en), 0);
        chk_i("rst_rid", int'(s_axi_rid), 0);
        chk_w("rst_rdata", s_axi_rdata, '0);
        chk_i("rst_rresp", int'(s_axi_rresp), 0);
        chk_i("rst_rlast", int'(s_axi_rlast), 0);
        chk_i("rst_dfx", int'(dfx_sta0), 0);
        sys_rst = 1'b0;
        @(negedge clk);
        chk_i("arready_first_cycle", int'(s_axi_arready), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk_i("arready_idle", int'(s_axi_arready), 1);
        @(posedge clk); #1;

        // Single-beat read
        s_axi_rready = 1'b1;
        rd_cyc.delete(); beat_cyc.delete();
        do_ar(4'd3, 64'h40, 8'd0, 3'd6, 2'b01, t);
        wait_drain(30);
        chk_i("single_rd_cycle", rd_cyc[0], t + 1);
        chk_i("single_rvalid_cycle", beat_cyc[0], t + L + 2);

        // Burst of 4, back-to-back
        rd_cyc.delete(); beat_cyc.delete();
        do_ar(4'd6, 64'h100, 8'd3, 3'd6, 2'b01, t);
        wait_drain(30);
        chk_i("burst_rd_count", rd_cyc.size(), 4);
        chk_i("burst_beat_count", beat_cyc.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk_i("burst_rd_cycle", rd_cyc[k], t + 1 + k);
            chk_i("burst_beat_cycle", beat_cyc[k], t + L + 2 + k);
        end

        // Backpressure
        s_axi_rready = 1'b0;
        rd_cyc.delete(); beat_cyc.delete();
        do_ar(4'd5, 64'h2000, 8'd15, 3'd6, 2'b01, t);
        tick(20);
        chk_i("bp_rd_count", rd_cyc.size(), 4);
        chk_i("bp_fifo_count", int'(dfx_sta0[29:24]), 4);
        @(negedge clk);
        chk_i("bp_mem_rd_en", int'(mem_rd_en), 0);
        chk_i("bp_rvalid", int'(s_axi_rvalid), 1);
        @(posedge clk); #1;
        s_axi_rready = 1'b1;
        wait_drain(120);
        chk_i("bp_beat_count", beat_cyc.size(), 16);
        chk_i("bp_rd_total", rd_cyc.size(), 16);

        // Back-to-back requests
        rd_cyc.delete(); beat_cyc.delete();
        do_ar(4'd1, 64'h800, 8'd1, 3'd6, 2'b01, t);
        do_ar(4'd2, 64'hC00, 8'd0, 3'd6, 2'b01, t2);
        chk_i("b2b_ar_gap", t2 - t, 3);
        wait_drain(30);
        chk_i("b2b_beat_count", beat_cyc.size(), 3);

        // Error response with word-address wrap
        do_ar(4'd7, 64'h3FFFC0, 8'd1, 3'b010, 2'b01, t);
        wait_drain(30);

        // DFX counters
        chk_i("dfx_ar_cnt", int'(dfx_sta0[15:8]), n_ar & 255);
        chk_i("dfx_rlast_cnt", int'(dfx_sta0[7:0]), n_rlast & 255);
        chk_i("dfx_idle_fields", int'(dfx_sta0[31:16]), 0);
        dfx_cfg0 = 32'h1;
        tick(1);
        chk_i("dfx_clear", int'(dfx_sta0[15:0]), 0);
        dfx_cfg0 = 32'h0;

        // Reset mid-burst
        rd_cyc.delete(); beat_cyc.delete();
        do_ar(4'd4, 64'h1000, 8'd7, 3'd6, 2'b01, t);
        tick(3);
        sys_rst = 1'b1;
        tick(1);
        sys_rst = 1'b0;
        sb.delete();
        exp_addr.delete();
        nb = beat_cyc.size();
        nr = rd_cyc.size();
        @(negedge clk);
        chk_i("midrst_rvalid", int'(s_axi_rvalid), 0);
        chk_i("midrst_arready", int'(s_axi_arready), 0);
        chk_i("midrst_mem_rd_en", int'(mem_rd_en), 0);
        chk_i("midrst_dfx", int'(dfx_sta0), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk_i("midrst_arready_back", int'(s_axi_arready), 1);
        @(posedge clk); #1;
        tick(10);
        chk_i("midrst_no_beats", beat_cyc.size(), nb);
        chk_i("midrst_no_reads", rd_cyc.size(), nr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
